// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
package pc_pkg;

  // Next-PC source selected by the control FSM.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_TARGET = 2'd1,
    PC_EPC    = 2'd2,
    PC_HOLD   = 2'd3
  } pc_src_e;

  // Reason recorded for the most recent trap.
  typedef enum logic {
    TRAP_EXT      = 1'b0,
    TRAP_MISALIGN = 1'b1
  } trap_cause_e;

  // Instruction size in bytes; sequential fetch advances by this amount.
  localparam int unsigned INSN_BYTES = 4;

  // True when an address is word aligned (low two bits clear).
  function automatic logic is_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/pc_if.sv
// Control/observation bundle between the control FSM and the PC unit.
interface pc_if
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) ();

  // Requests from the control FSM.
  logic              pc_en;
  pc_src_e           pc_src;
  logic [XLEN-1:0]   target;
  logic              trap_req;

  // State published by the PC unit.
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_old;
  logic [XLEN-1:0]   epc;
  logic              trap_taken;
  logic              trap_cause;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  instret;

  // Control FSM side: issues updates and observes the PC state.
  modport master (
    output pc_en, pc_src, target, trap_req,
    input  pc, pc_old, epc, trap_taken, trap_cause, cycles, instret
  );

  // PC unit side: consumes updates and owns the PC state.
  modport slave (
    input  pc_en, pc_src, target, trap_req,
    output pc, pc_old, epc, trap_taken, trap_cause, cycles, instret
  );

endinterface

// File: rtl/pc_event_counter.sv
// Wrapping event counter, cleared asynchronously while reset is low.
module pc_event_counter #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Advance by one on every enabled edge; wraps at 2^W naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, trap redirection, history and counters.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_1000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     CNT_W        = 64
) (
  input  logic clk,
  input  logic reset,
  pc_if.slave  bus
);

  // Vectors must be fetchable addresses.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("pc_unit: RESET_VECTOR low two bits must be zero");
  end
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("pc_unit: TRAP_VECTOR low two bits must be zero");
  end

  logic [XLEN-1:0] nxt;
  logic            update;
  logic            misalign;
  logic            commit;

  // Candidate next address for the requested source.
  always_comb begin
    nxt = bus.pc;
    unique case (bus.pc_src)
      PC_SEQ:    nxt = bus.pc + XLEN'(INSN_BYTES);
      PC_TARGET: nxt = bus.target;
      PC_EPC:    nxt = bus.epc;
      PC_HOLD:   nxt = bus.pc;
      default:   nxt = bus.pc;
    endcase
  end

  // Classify the cycle: external trap outranks a misaligned fault, which outranks a commit.
  always_comb begin
    update   = bus.pc_en && (bus.pc_src != PC_HOLD);
    misalign = update && !is_aligned(nxt[1:0]);
    commit   = update && !misalign && !bus.trap_req;
  end

  // PC, history, trap bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.pc         <= RESET_VECTOR;
      bus.pc_old     <= RESET_VECTOR;
      bus.epc        <= '0;
      bus.trap_taken <= 1'b0;
      bus.trap_cause <= TRAP_EXT;
    end else if (bus.trap_req) begin
      bus.pc         <= TRAP_VECTOR;
      bus.pc_old     <= bus.pc;
      bus.epc        <= bus.pc;
      bus.trap_taken <= 1'b1;
      bus.trap_cause <= TRAP_EXT;
    end else if (misalign) begin
      // The faulting instruction's own PC is what the handler returns to.
      bus.pc         <= TRAP_VECTOR;
      bus.pc_old     <= bus.pc;
      bus.epc        <= bus.pc;
      bus.trap_taken <= 1'b1;
      bus.trap_cause <= TRAP_MISALIGN;
    end else if (commit) begin
      bus.pc         <= nxt;
      bus.pc_old     <= bus.pc;
      bus.trap_taken <= 1'b0;
    end else begin
      bus.trap_taken <= 1'b0;
    end
  end

  // Free-running cycle counter.
  pc_event_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .count (bus.cycles)
  );

  // Retired-update counter; trapping cycles do not retire.
  pc_event_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .reset (reset),
    .inc   (commit),
    .count (bus.instret)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit with a behavioural reference model.
module tb_pc_unit;
  import pc_pkg::*;

  localparam logic [31:0] RV = 32'h0000_1000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference model state
  logic [31:0] m_pc, m_old, m_epc;
  logic        m_cause, m_taken;
  logic [63:0] m_cycles, m_instret;

  pc_if #(.XLEN(32), .CNT_W(64)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV; m_old = RV; m_epc = '0;
    m_cause = 1'b0; m_taken = 1'b0;
    m_cycles = '0; m_instret = '0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic tick(input logic en, input pc_src_e src, input logic [31:0] tgt,
                      input logic trap);
    logic [31:0] nxt;
    bit          upd;
    bus.pc_en = en; bus.pc_src = src; bus.target = tgt; bus.trap_req = trap;
    @(posedge clk);
    case (src)
      PC_SEQ:    nxt = m_pc + 32'd4;
      PC_TARGET: nxt = tgt;
      PC_EPC:    nxt = m_epc;
      default:   nxt = m_pc;
    endcase
    upd = en && (src != PC_HOLD);
    if (trap) begin
      m_epc = m_pc; m_old = m_pc; m_pc = TV; m_cause = 1'b0; m_taken = 1'b1;
    end else if (upd && (nxt % 4 != 0)) begin
      m_epc = m_pc; m_old = m_pc; m_pc = TV; m_cause = 1'b1; m_taken = 1'b1;
    end else if (upd) begin
      m_old = m_pc; m_pc = nxt; m_instret = m_instret + 64'd1; m_taken = 1'b0;
    end else begin
      m_taken = 1'b0;
    end
    m_cycles = m_cycles + 64'd1;
    #1;
    bus.pc_en = 1'b0; bus.pc_src = PC_HOLD; bus.target = '0; bus.trap_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.pc_en = 1'b0; bus.pc_src = PC_HOLD; bus.target = '0; bus.trap_req = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.pc !== 32'h1000) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc, 32'h1000); end
    n_checks++; if (bus.pc_old !== 32'h1000) begin n_fail++; $display("FAIL reset_pc_old got %h want %h", bus.pc_old, 32'h1000); end
    n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", bus.epc); end
    n_checks++; if (bus.trap_taken !== 1'b0 || bus.trap_cause !== 1'b0) begin n_fail++; $display("FAIL reset_trap got %b/%b want 0/0", bus.trap_taken, bus.trap_cause); end
    n_checks++; if (bus.cycles !== 64'd0 || bus.instret !== 64'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", bus.cycles, bus.instret); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick(1'b0, PC_SEQ, 32'h0, 1'b0);
    n_checks++; if (bus.cycles !== 64'd5) begin n_fail++; $display("FAIL idle_cycles got %0d want 5", bus.cycles); end
    n_checks++; if (bus.instret !== 64'd0) begin n_fail++; $display("FAIL idle_instret got %0d want 0", bus.instret); end
    n_checks++; if (bus.pc !== 32'h1000) begin n_fail++; $display("FAIL idle_pc got %h want %h", bus.pc, 32'h1000); end
  endtask

  task automatic test_sequential();
    repeat (3) tick(1'b1, PC_SEQ, 32'h0, 1'b0);
    n_checks++; if (bus.pc !== 32'h100C) begin n_fail++; $display("FAIL seq_pc got %h want %h", bus.pc, 32'h100C); end
    n_checks++; if (bus.pc_old !== 32'h1008) begin n_fail++; $display("FAIL seq_pc_old got %h want %h", bus.pc_old, 32'h1008); end
    n_checks++; if (bus.instret !== 64'd3) begin n_fail++; $display("FAIL seq_instret got %0d want 3", bus.instret); end
  endtask

  task automatic test_branch_hold();
    tick(1'b1, PC_TARGET, 32'h2000, 1'b0);
    n_checks++; if (bus.pc !== 32'h2000) begin n_fail++; $display("FAIL branch_pc got %h want %h", bus.pc, 32'h2000); end
    n_checks++; if (bus.pc_old !== 32'h100C) begin n_fail++; $display("FAIL branch_pc_old got %h want %h", bus.pc_old, 32'h100C); end
    tick(1'b1, PC_HOLD, 32'h4444, 1'b0);
    n_checks++; if (bus.pc !== 32'h2000) begin n_fail++; $display("FAIL hold_pc got %h want %h", bus.pc, 32'h2000); end
    n_checks++; if (bus.instret !== 64'd4) begin n_fail++; $display("FAIL hold_instret got %0d want 4", bus.instret); end
  endtask

  task automatic test_misaligned();
    tick(1'b1, PC_TARGET, 32'h2002, 1'b0);
    n_checks++; if (bus.pc !== TV) begin n_fail++; $display("FAIL mis_pc got %h want %h", bus.pc, TV); end
    n_checks++; if (bus.epc !== 32'h2000) begin n_fail++; $display("FAIL mis_epc got %h want %h", bus.epc, 32'h2000); end
    n_checks++; if (bus.trap_cause !== 1'b1) begin n_fail++; $display("FAIL mis_cause got %b want 1", bus.trap_cause); end
    n_checks++; if (bus.trap_taken !== 1'b1) begin n_fail++; $display("FAIL mis_taken got %b want 1", bus.trap_taken); end
    n_checks++; if (bus.instret !== 64'd4) begin n_fail++; $display("FAIL mis_instret got %0d want 4", bus.instret); end
    tick(1'b0, PC_SEQ, 32'h0, 1'b0);
    n_checks++; if (bus.trap_taken !== 1'b0) begin n_fail++; $display("FAIL mis_taken_drop got %b want 0", bus.trap_taken); end
  endtask

  task automatic test_trap_priority();
    tick(1'b1, PC_TARGET, 32'h2004, 1'b0);
    tick(1'b1, PC_TARGET, 32'h3000, 1'b1);
    n_checks++; if (bus.pc !== TV) begin n_fail++; $display("FAIL ext_pc got %h want %h", bus.pc, TV); end
    n_checks++; if (bus.epc !== 32'h2004) begin n_fail++; $display("FAIL ext_epc got %h want %h", bus.epc, 32'h2004); end
    n_checks++; if (bus.trap_cause !== 1'b0) begin n_fail++; $display("FAIL ext_cause got %b want 0", bus.trap_cause); end
    n_checks++; if (bus.instret !== 64'd5) begin n_fail++; $display("FAIL ext_instret got %0d want 5", bus.instret); end
    tick(1'b1, PC_EPC, 32'h0, 1'b0);
    n_checks++; if (bus.pc !== 32'h2004) begin n_fail++; $display("FAIL eret_pc got %h want %h", bus.pc, 32'h2004); end
    n_checks++; if (bus.instret !== 64'd6) begin n_fail++; $display("FAIL eret_instret got %0d want 6", bus.instret); end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, PC_SEQ, 32'h0, 1'b1);
    tick(1'b0, PC_SEQ, 32'h0, 1'b1);
    n_checks++; if (bus.trap_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_taken got %b want 1", bus.trap_taken); end
    n_checks++; if (bus.epc !== TV) begin n_fail++; $display("FAIL b2b_epc got %h want %h", bus.epc, TV); end
    n_checks++; if (bus.pc_old !== TV) begin n_fail++; $display("FAIL b2b_pc_old got %h want %h", bus.pc_old, TV); end
  endtask

  task automatic test_wrap();
    tick(1'b1, PC_TARGET, 32'hFFFF_FFFC, 1'b0);
    tick(1'b1, PC_SEQ, 32'h0, 1'b0);
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", bus.pc); end
    n_checks++; if (bus.pc_old !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc_old got %h want %h", bus.pc_old, 32'hFFFF_FFFC); end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int i = 0; i < 300; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      tick($urandom_range(0, 3) != 0, pc_src_e'($urandom_range(0, 3)), tgt,
           $urandom_range(0, 15) == 0);
      n_checks++; if (bus.pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, bus.pc, m_pc); end
      n_checks++; if (bus.pc_old !== m_old) begin n_fail++; $display("FAIL rnd_pc_old[%0d] got %h want %h", i, bus.pc_old, m_old); end
      n_checks++; if (bus.epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d] got %h want %h", i, bus.epc, m_epc); end
      n_checks++; if (bus.trap_taken !== m_taken) begin n_fail++; $display("FAIL rnd_taken[%0d] got %b want %b", i, bus.trap_taken, m_taken); end
      n_checks++; if (bus.trap_cause !== m_cause) begin n_fail++; $display("FAIL rnd_cause[%0d] got %b want %b", i, bus.trap_cause, m_cause); end
      n_checks++; if (bus.cycles !== m_cycles) begin n_fail++; $display("FAIL rnd_cycles[%0d] got %0d want %0d", i, bus.cycles, m_cycles); end
      n_checks++; if (bus.instret !== m_instret) begin n_fail++; $display("FAIL rnd_instret[%0d] got %0d want %0d", i, bus.instret, m_instret); end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, PC_SEQ, 32'h0, 1'b1);
    n_checks++; if (bus.pc !== TV || bus.trap_taken !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %h/%b want %h/1", bus.pc, bus.trap_taken, TV); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.pc !== RV || bus.pc_old !== RV) begin n_fail++; $display("FAIL arst_pc got %h/%h want %h", bus.pc, bus.pc_old, RV); end
    n_checks++; if (bus.epc !== 32'h0) begin n_fail++; $display("FAIL arst_epc got %h want 0", bus.epc); end
    n_checks++; if (bus.trap_taken !== 1'b0 || bus.trap_cause !== 1'b0) begin n_fail++; $display("FAIL arst_trap got %b/%b want 0/0", bus.trap_taken, bus.trap_cause); end
    n_checks++; if (bus.cycles !== 64'd0 || bus.instret !== 64'd0) begin n_fail++; $display("FAIL arst_counters got %0d/%0d want 0/0", bus.cycles, bus.instret); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, PC_SEQ, 32'h0, 1'b0);
    n_checks++; if (bus.pc !== 32'h1004 || bus.cycles !== 64'd1 || bus.instret !== 64'd1) begin n_fail++; $display("FAIL arst_resume got pc=%h cyc=%0d ret=%0d want 1004/1/1", bus.pc, bus.cycles, bus.instret); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_branch_hold();
    test_misaligned();
    test_trap_priority();
    test_back_to_back();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multicycle RISC-V core, the next generation of the fetch-address register. It holds the PC and selects the next PC: sequential, datapath target, or exception return. It also redirects to a trap vector on an external trap request or on a misaligned control-flow target. It keeps the previous PC, the exception PC, and free-running cycle and retired-update counters. The control FSM drives it once per instruction; it feeds instruction memory and the ALU operand muxes.

## Interface
Parameters:
- XLEN, 32, address and PC width.
- RESET_VECTOR, 32'h0000_1000, PC value after reset; low 2 bits must be zero.
- TRAP_VECTOR, 32'h0000_0100, PC value after any trap; low 2 bits must be zero.
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- pc_en  in  1  commit a PC update this cycle, from the control FSM.
- pc_src  in  2  next-PC select: 0 SEQ, 1 TARGET, 2 EPC, 3 HOLD.
- target  in  XLEN  branch/jump target computed by the datapath.
- trap_req  in  1  external trap/interrupt request; honoured regardless of pc_en.
- pc  out  XLEN  current PC.
- pc_old  out  XLEN  PC value before the most recent update.
- epc  out  XLEN  PC captured at the last trap.
- trap_taken  out  1  one-cycle pulse, high while pc first equals TRAP_VECTOR after a trap.
- trap_cause  out  1  cause of the last trap: 0 external, 1 misaligned target.
- cycles  out  CNT_W  cycles since reset release.
- instret  out  CNT_W  count of committed non-trap PC updates.

## Operation
**Reset.** While reset = 0, all outputs are forced immediately, without waiting for a clock edge:
- pc = pc_old = RESET_VECTOR
- epc = 0
- trap_taken = 0, trap_cause = 0
- cycles = 0, instret = 0

**Next-address candidate (nxt):**
- SEQ = pc + 4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.
- TARGET = target.
- EPC = epc.
- HOLD: no update.

**Per-cycle priority, highest first:**
1. trap_req = 1: pc ← TRAP_VECTOR, epc ← pc, pc_old ← pc, trap_cause ← 0, trap_taken ← 1. Applies whether or not pc_en is asserted. instret unchanged.
2. pc_en = 1, pc_src ≠ HOLD, nxt[1:0] ≠ 0: misaligned fault. pc ← TRAP_VECTOR, epc ← pc (the faulting instruction), pc_old ← pc, trap_cause ← 1, trap_taken ← 1. instret unchanged.
3. pc_en = 1, pc_src ≠ HOLD, aligned: pc ← nxt, pc_old ← pc, instret += 1.
4. Otherwise (pc_en = 0, or HOLD): all state holds; trap_taken ← 0.

**Other rules:**
- trap_taken is registered. It is high for exactly one cycle after each trap edge. Back-to-back traps keep it high.
- cycles increments every clock while reset = 1 and wraps at 2^CNT_W. instret also wraps.
- A trap while pc = TRAP_VECTOR re-enters the vector with epc = TRAP_VECTOR.
- Reset asserted mid-operation discards any pending update and forces the reset values above.

## Timing
- Single-cycle latency: inputs sampled at posedge N appear on pc, pc_old, epc, trap_cause and trap_taken after posedge N.
- No combinational path from any input to any output.
- pc_src, target and trap_req must be stable in the setup window before the edge. No handshake; the FSM owns sequencing.
- Reset release is synchronised upstream. The first counted cycle is the first posedge with reset = 1.

## Structure
- Package pc_pkg:
  - pc_src_e enum: PC_SEQ = 2'd0, PC_TARGET = 2'd1, PC_EPC = 2'd2, PC_HOLD = 2'd3.
  - trap_cause_e enum: TRAP_EXT = 1'b0, TRAP_MISALIGN = 1'b1.
  - Constant INSN_BYTES = 4.
- Elaboration-time assertions that the low 2 bits of RESET_VECTOR and TRAP_VECTOR are zero.
- One sub-module, pc_event_counter (parameter W, inputs clk/reset/inc, output count). Instantiated twice: cycles with inc = 1, instret with inc = commit.

## Test plan
- Reset: hold reset = 0, then release → pc = pc_old = 0x1000, epc = 0, counters 0. After 5 clocks with pc_en = 0 → cycles = 5, instret = 0, pc = 0x1000.
- Sequential and wrap: pc_en = 1, SEQ for 3 cycles → pc = 0x100C, pc_old = 0x1008, instret = 3. Separately, force pc = 0xFFFF_FFFC via target, then SEQ → pc = 0.
- Branch and hold: TARGET with target = 0x2000 → pc = 0x2000, pc_old = 0x100C. Then HOLD with pc_en = 1 → pc and instret unchanged.
- Misaligned: at pc = 0x2000, TARGET with target = 0x2002 → pc = 0x100, epc = 0x2000, trap_cause = 1, trap_taken high exactly one cycle, instret unchanged.
- External trap priority: trap_req = 1 together with pc_en = 1, TARGET 0x3000 at pc = 0x2004 → pc = 0x100, epc = 0x2004, cause = 0. Then EPC select → pc = 0x2004, instret += 1.
- Async reset mid-run: assert reset between edges while pc = 0x100 and trap_taken = 1 → all outputs return to reset values before the next edge.
